file_reg_mp: RTL and testbench
==============================

# file_reg_mp

Parametrised multi-port register file: the next generation of the 32×32, two-read/one-write file register used by the datapath. Width, depth and read-port count are parameters. Adds byte-enable writes, an optional hardwired-zero entry 0, optional write-to-read bypass, and a sequential clear engine. Storage has no per-entry reset, so it maps to distributed RAM. The block sits between the instruction decoder (read addresses) and the writeback stage (write port).

## Interface
- DATA_W, 32, entry width in bits; must be a multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_R0, 1, 1: entry 0 always reads 0 and writes to it are dropped
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  single-cycle request to zero all entries
- busy  out  1  clear sweep in progress
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]

## Operation
- FSM states: CLEAR, IDLE. Sweep counter cnt is ADDR_W bits wide.
- Reset (rst_n=0): state=CLEAR, cnt=0, busy=1, rdata=all zeros.
- Every entry is cleared after reset, because the storage itself is never reset.
- CLEAR, each clock: mem[cnt]<=0, cnt<=cnt+1. When cnt==DEPTH-1, go to IDLE.
- CLEAR behaviour:
  - we is ignored.
  - rdata is forced to 0 on all ports.
  - clr restarts the sweep: cnt<=0 and that cycle's cleared entry is skipped.
- IDLE, clr=1: go to CLEAR with cnt=0. A write in the same cycle is dropped, so clr has priority.
- IDLE, we=1: each byte of mem[waddr] with wbe set takes the matching wdata byte; other bytes hold. A write with wbe=0 is a no-op.
- Read is combinational: rdata_k = mem[raddr_k].
- ZERO_R0=1: raddr_k==0 gives 0, and writes to address 0 are discarded. This includes bypass.
- BYPASS=1, IDLE, we=1 and raddr_k==waddr: rdata_k is the merged value (enabled bytes from wdata, others from mem). All ports may match at once.
- BYPASS=0: rdata_k shows old contents until the edge after the write.

## Timing
- Read latency: 0 cycles, combinational from raddr/mem.
- Write is visible via mem on the cycle after the write edge, or the same cycle with BYPASS=1.
- busy stays high through reset. After rst_n rises, it remains high for exactly DEPTH rising edges, then drops on the edge that clears entry DEPTH-1.
- clr sampled at edge T makes busy=1 from T through T+DEPTH; the block is back in IDLE after edge T+DEPTH.
- Reset asserted mid-sweep or mid-write: the state returns to CLEAR and cnt to 0 immediately. The sweep restarts after deassertion.
- cnt wraps DEPTH-1→0 only as it exits CLEAR. It holds at 0 in IDLE.

## Structure
- Package file_reg_pkg holds:
  - the state enum (CLEAR, IDLE)
  - default parameter constants (DATA_W=32, ADDR_W=5, NUM_RD=2)
  - a byte-merge function, merge(old, new, be), shared by the write path and the bypass path
- Sub-module file_reg_clr_fsm holds the FSM, cnt and busy. It outputs clr_we and clr_addr to the array.
- Top level holds the storage array (no reset), the write mux (the sweep has priority over the user write) and the NUM_RD read/bypass muxes, built with a generate loop.

## Test plan
- Reset release, DEPTH=32: busy=1 for 32 edges then 0. Every address on every port reads 0x00000000. A write attempted at cycle 5 is not stored.
- Write 0xDEADBEEF to 1 with wbe=4'hF, then 0x0000AA00 to 1 with wbe=4'b0010. Next cycle, raddr0=1 reads 0xDEADAAEF.
- ZERO_R0=1: write 0xCAFEBABE to 0. Read 0 gives 0 on both ports, including the same cycle with bypass.
- BYPASS=1: write 0x12345678 to 2 with raddr0=raddr1=2 in the same cycle. Both ports show 0x12345678 before the edge. With BYPASS=0 they show the old value until after the edge.
- Fill entries 1..3, pulse clr together with we to 4: busy=1 for 32 cycles, rdata=0 throughout, and entries 1..4 read 0 afterwards.
- Mid-sweep: clr at sweep cycle 10 restarts the sweep (busy lasts 32 more edges). rst_n pulsed low at cycle 20 forces busy=1 and restarts the sweep from 0.

Source files
------------

// File: rtl/file_reg_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state
// encoding, default geometry and the byte-merge used by write and bypass paths.
package file_reg_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // merge() works on a fixed wide word; callers cast in and out of it so any
  // DATA_W up to MERGE_W can share one implementation.
  localparam int MERGE_W = 256;
  localparam int MERGE_B = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0] old_v,
    input logic [MERGE_W-1:0] new_v,
    input logic [MERGE_B-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MERGE_B; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/file_reg_clr_fsm.sv
// Clear sequencer: sweeps every entry to zero after reset or on a clr request,
// issuing one clear write per clock and holding busy high while it runs.
module file_reg_clr_fsm
  import file_reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          // Restart: this cycle's entry is not written, the sweep begins again at 0.
          cnt_d = '0;
        end else begin
          clr_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

endmodule

// File: rtl/file_reg_mp.sv
// Parametrised multi-port register file with byte-enable writes, optional
// hardwired-zero entry 0, optional write-to-read bypass and a clear sweep.
module file_reg_mp
  import file_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;
  logic [DATA_W-1:0] wr_merged;

  // Storage deliberately has no reset so it maps onto distributed RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  file_reg_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clr request in the same cycle wins over the user write.
  assign usr_we = we && !busy && !clr && !(ZERO_R0 && (waddr == '0));

  assign wr_merged = DATA_W'(merge(MERGE_W'(mem[waddr]), MERGE_W'(wdata), MERGE_B'(wbe)));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (usr_we) begin
      mem[waddr] <= wr_merged;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if (BYPASS && usr_we && (ra == waddr)) rd = wr_merged;
      if (busy || (ZERO_R0 && (ra == '0))) rd = '0;
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_file_reg_mp.sv
// Directed bench for file_reg_mp: a bypassing and a non-bypassing instance
// share stimulus; each task checks one feature against hand-computed values.
module tb_file_reg_mp;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [63:0] rdata_nb;
  logic        busy;
  logic        busy_nb;

  int vec_cnt = 0;
  int err_cnt = 0;

  file_reg_mp #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .ZERO_R0 (1'b1), .BYPASS (1'b1)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .clr (clr), .busy (busy), .we (we),
    .waddr (waddr), .wbe (wbe), .wdata (wdata), .raddr (raddr), .rdata (rdata)
  );

  file_reg_mp #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .ZERO_R0 (1'b1), .BYPASS (1'b0)
  ) u_nobyp (
    .clk (clk), .rst_n (rst_n), .clr (clr), .busy (busy_nb), .we (we),
    .waddr (waddr), .wbe (wbe), .wdata (wdata), .raddr (raddr), .rdata (rdata_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
    raddr = '0;
    repeat (3) @(posedge clk);
    #1 raddr = {5'd7, 5'd5};
    #1;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
    vec_cnt++;
    if (rdata !== 64'h0) begin
      err_cnt++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
        raddr = {5'd2, 5'd2};
        #1;
        vec_cnt++;
        if (rdata !== 64'h0) begin
          err_cnt++; $display("FAIL sweep_bypass_forced: got %h expected 0", rdata);
        end
      end
      if (e == 6) we = 1'b0;
      if (e == 31) begin
        vec_cnt++;
        if (busy !== 1'b1) begin
          err_cnt++; $display("FAIL busy_edge31: got %b expected 1", busy);
        end
      end
      if (e == 32) begin
        vec_cnt++;
        if (busy !== 1'b0 || busy_nb !== 1'b0) begin
          err_cnt++; $display("FAIL busy_edge32: got %b/%b expected 0/0", busy, busy_nb);
        end
      end
    end
    for (int a = 0; a < 32; a++) begin
      tick();
      raddr = {5'(a), 5'(31 - a)};
      #1;
      vec_cnt++;
      if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
        err_cnt++;
        $display("FAIL post_reset_read a=%0d: got %h/%h expected 0", a, rdata, rdata_nb);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_byte_write();
    tick();
    we = 1'b1; waddr = 5'd1; wdata = 32'hDEAD_BEEF; wbe = 4'hF; raddr = {5'd0, 5'd1};
    tick();
    wdata = 32'h0000_AA00; wbe = 4'b0010;
    #1;
    vec_cnt++;
    if (rdata[31:0] !== 32'hDEAD_AAEF) begin
      err_cnt++; $display("FAIL byte_bypass: got %h expected deadaaef", rdata[31:0]);
    end
    vec_cnt++;
    if (rdata_nb[31:0] !== 32'hDEAD_BEEF) begin
      err_cnt++; $display("FAIL byte_nobypass_old: got %h expected deadbeef", rdata_nb[31:0]);
    end
    tick();
    we = 1'b0;
    #1;
    vec_cnt++;
    if (rdata[31:0] !== 32'hDEAD_AAEF || rdata_nb[31:0] !== 32'hDEAD_AAEF) begin
      err_cnt++;
      $display("FAIL byte_merge: got %h/%h expected deadaaef", rdata[31:0], rdata_nb[31:0]);
    end
    tick();
    we = 1'b1; wbe = 4'h0; wdata = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    #1;
    vec_cnt++;
    if (rdata[31:0] !== 32'hDEAD_AAEF) begin
      err_cnt++; $display("FAIL wbe_zero_noop: got %h expected deadaaef", rdata[31:0]);
    end
    $display("test_byte_write: done");
  endtask

  task automatic test_zero_r0();
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 32'hCAFE_BABE; wbe = 4'hF; raddr = {5'd0, 5'd0};
    #1;
    vec_cnt++;
    if (rdata !== 64'h0) begin
      err_cnt++; $display("FAIL zero_r0_bypass: got %h expected 0", rdata);
    end
    tick();
    we = 1'b0;
    #1;
    vec_cnt++;
    if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
      err_cnt++; $display("FAIL zero_r0_read: got %h/%h expected 0", rdata, rdata_nb);
    end
    $display("test_zero_r0: done");
  endtask

  task automatic test_bypass();
    tick();
    we = 1'b1; waddr = 5'd2; wdata = 32'h1111_1111; wbe = 4'hF;
    tick();
    wdata = 32'h1234_5678; raddr = {5'd2, 5'd2};
    #1;
    vec_cnt++;
    if (rdata !== {2{32'h1234_5678}}) begin
      err_cnt++; $display("FAIL bypass_both_ports: got %h expected 12345678 x2", rdata);
    end
    vec_cnt++;
    if (rdata_nb !== {2{32'h1111_1111}}) begin
      err_cnt++; $display("FAIL nobypass_old_value: got %h expected 11111111 x2", rdata_nb);
    end
    tick();
    wbe = 4'b0001; wdata = 32'h0000_00AB;
    #1;
    vec_cnt++;
    if (rdata[31:0] !== 32'h1234_56AB || rdata_nb[31:0] !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL bypass_partial: got %h/%h expected 123456ab/12345678", rdata[31:0], rdata_nb[31:0]);
    end
    tick();
    we = 1'b0;
    #1;
    vec_cnt++;
    if (rdata[63:32] !== 32'h1234_56AB || rdata_nb[63:32] !== 32'h1234_56AB) begin
      err_cnt++;
      $display("FAIL bypass_after_edge: got %h/%h expected 123456ab", rdata[63:32], rdata_nb[63:32]);
    end
    $display("test_bypass: done");
  endtask

  task automatic test_clear();
    for (int a = 1; a <= 3; a++) begin
      tick();
      we = 1'b1; waddr = 5'(a); wdata = 32'hA000_0000 | 32'(a); wbe = 4'hF;
    end
    tick();
    we = 1'b0; raddr = {5'd3, 5'd1};
    #1;
    vec_cnt++;
    if (rdata !== {32'hA000_0003, 32'hA000_0001}) begin
      err_cnt++; $display("FAIL clear_fill: got %h expected a0000003a0000001", rdata);
    end
    tick();
    clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h4444_4444; raddr = {5'd4, 5'd1};
    #1;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL clear_pre_busy: got %b expected 0", busy);
    end
    tick();
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      vec_cnt++;
      if (busy !== 1'b1 || rdata !== 64'h0) begin
        err_cnt++;
        $display("FAIL clear_sweep i=%0d: got busy=%b rdata=%h expected busy=1 rdata=0", i, busy, rdata);
      end
      tick();
    end
    #1;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL clear_done: got %b expected 0", busy);
    end
    for (int a = 1; a <= 4; a++) begin
      tick();
      raddr = {5'(a), 5'(a)};
      #1;
      vec_cnt++;
      if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
        err_cnt++;
        $display("FAIL clear_entry a=%0d: got %h/%h expected 0", a, rdata, rdata_nb);
      end
    end
    $display("test_clear: done");
  endtask

  task automatic test_mid_sweep();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (22) tick();
    #1;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL restart_edge22: got %b expected 1", busy);
    end
    repeat (9) tick();
    #1;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL restart_edge31: got %b expected 1", busy);
    end
    tick();
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL restart_edge32: got %b expected 0", busy);
    end

    // Reset in the middle of a sweep.
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (19) tick();
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 31) begin
        vec_cnt++;
        if (busy !== 1'b1) begin
          err_cnt++; $display("FAIL rst_sweep_edge31: got %b expected 1", busy);
        end
      end
      if (e == 32) begin
        vec_cnt++;
        if (busy !== 1'b0) begin
          err_cnt++; $display("FAIL rst_sweep_edge32: got %b expected 0", busy);
        end
      end
    end

    // Reset in the middle of a write.
    tick();
    we = 1'b1; waddr = 5'd6; wdata = 32'h6666_6666; wbe = 4'hF; raddr = {5'd6, 5'd6};
    #1;
    vec_cnt++;
    if (rdata !== {2{32'h6666_6666}}) begin
      err_cnt++; $display("FAIL midwrite_bypass: got %h expected 66666666 x2", rdata);
    end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (busy !== 1'b1 || rdata !== 64'h0) begin
      err_cnt++; $display("FAIL midwrite_reset: got busy=%b rdata=%h expected busy=1 rdata=0", busy, rdata);
    end
    we = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (32) tick();
    vec_cnt++;
    if (busy !== 1'b0 || rdata !== 64'h0) begin
      err_cnt++; $display("FAIL midwrite_after: got busy=%b rdata=%h expected busy=0 rdata=0", busy, rdata);
    end
    $display("test_mid_sweep: done");
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_zero_r0();
    test_bypass();
    test_clear();
    test_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
